seq_factorizer: RTL and testbench
=================================

# seq_factorizer

Sequential prime-factorisation engine, the parametrised next generation of the fixed 8-bit factorizer core behind the Tiny Tapeout top `tt_um_marno_factorizer`. It accepts a `WIDTH`-bit integer on a start pulse, finds its prime factors by iterative trial division with a bit-serial restoring divider, and streams them in ascending order, with multiplicity, over a valid/ready handshake. A downstream display stage consumes the stream and applies its own `MAX_COUNT` dwell; that dwell is not part of this block. Status flags report zero, prime, busy, done and factor count.

## Interface
Parameters:
- `WIDTH`, default 8: operand and factor width; legal range 4..16.
- `CW`, default `$clog2(WIDTH+1)`: factor-count width (derived; not to be overridden).

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low; clears all state.
- `ena`  in  1  clock enable. Low freezes all state; outputs hold.
- `start`  in  1  start pulse; sampled only in IDLE or DONE.
- `n_in`  in  WIDTH  operand; captured on an accepted `start`.
- `factor_out`  out  WIDTH  current factor; stable while `factor_valid` is high.
- `factor_valid`  out  1  factor presented.
- `factor_ready`  in  1  consumer accepts the factor.
- `factor_last`  out  1  qualifies `factor_valid`: this is the final factor.
- `busy`  out  1  high from an accepted start until entry to DONE.
- `done`  out  1  high in DONE; cleared by the next accepted start.
- `is_zero`  out  1  captured operand was 0; valid while `done` is high.
- `is_prime`  out  1  operand is prime; valid while `done` is high.
- `factor_count`  out  CW  number of factors handed over so far.

## Operation
- States: IDLE, CHECK, DIV, EMIT, DONE. Reset sets state IDLE and every output to 0.
- Accepted start (`ena` high and `start` high in IDLE/DONE):
  - loads `rem`=`n_in`, `d`=2, `sq`=4 (width 2·WIDTH), `factor_count`=0;
  - clears `done`, `is_zero`, `is_prime`; sets `busy`;
  - goes to CHECK.
- `start` in any other state is ignored.
- CHECK, first matching rule wins:
  - `rem`==0: `is_zero`=1, go to DONE.
  - `rem`==1: go to DONE.
  - `sq` > `rem`: present `rem` as a factor with `factor_last`=1, go to EMIT. This is the tail factor.
  - Otherwise go to DIV.
- DIV: restoring divide of `rem` by `d`, one quotient bit per cycle, MSB first, WIDTH cycles. Then:
  - remainder 0: present `d`, set `factor_last`=(quotient==1), load `rem`=quotient (keep `d`), go to EMIT.
  - remainder nonzero: `sq`+=2·`d`+1, `d`+=1, go to CHECK.
- EMIT:
  - hold `factor_valid`=1 until `factor_ready`.
  - on the handshake cycle: `factor_count`+=1; if `factor_last`, go to DONE, else go to CHECK.
  - for a tail factor, `rem` becomes 1.
- DONE:
  - `busy`=0, `done`=1; flags hold until the next accepted start.
  - `is_prime`=1 exactly when `factor_count`==1 and that factor equals the captured operand (operand ≥2).
- `factor_valid` is never high outside EMIT. Operands 0 and 1 produce no factors.
- Arithmetic: `d` and `rem` are WIDTH bits. `sq` is 2·WIDTH bits and cannot overflow, because `d` never exceeds sqrt(2^WIDTH)+1.

## Timing
- Accepted start → `busy` high the next cycle; first CHECK the cycle after the start edge.
- Each CHECK costs 1 cycle; each DIV costs exactly WIDTH cycles.
- EMIT: 1 cycle with `factor_ready` already high, plus 1 per stall cycle.
- `factor_valid` rises the cycle after the decision (CHECK exit or DIV end), never combinationally.
- `factor_out`/`factor_last` may change only the cycle after a handshake.
- `done` rises the cycle after the final handshake, or after the CHECK that saw `rem`≤1 for operands 0/1.
- `ena` low: no state, counter or divider bit advances. A handshake counts only if `ena` and `factor_ready` are both high in EMIT.
- `rst_n` low at any time, including mid-DIV or mid-EMIT: immediate return to IDLE with all outputs 0. No factor is emitted after reset.
- Worst case (prime near 2^WIDTH): about sqrt(2^WIDTH)·(WIDTH+1) cycles.

## Test plan
- WIDTH=8, `n_in`=12, `factor_ready`=1 → handshakes 2, 2, 3. Only the 3 has `factor_last`. Then `done`=1, `factor_count`=3, `is_prime`=0.
- `n_in`=251 → single factor 251 with `factor_last`=1, then `is_prime`=1, `factor_count`=1.
- `n_in`=0 → no `factor_valid`; `done`=1, `is_zero`=1, `factor_count`=0. `n_in`=1 → no `factor_valid`; `done`=1, `is_zero`=0, `is_prime`=0.
- `n_in`=200 with `factor_ready` toggling randomly and `ena` low in bursts → stream 2, 2, 2, 5, 5, with `factor_out` stable during stalls. `start` pulsed mid-run is ignored.
- `rst_n` pulsed low mid-DIV on `n_in`=221 → all outputs 0 immediately. A new start with `n_in`=221 then yields 13, 17.
- WIDTH=12, `n_in`=4095 → factors 3, 3, 5, 7, 13; `factor_count`=5.

Source files
------------

// File: rtl/seq_factorizer.sv
// seq_factorizer
//
// Sequential prime-factorisation engine. A WIDTH-bit operand is captured on
// an accepted start pulse and factored by trial division. Each trial uses a
// bit-serial restoring divider that takes WIDTH cycles. Prime factors leave
// in ascending order, with multiplicity, over a valid/ready handshake.
//
// Ports:
//   clk           single clock, all state on the rising edge
//   rst_n         asynchronous active-low reset, clears all state
//   ena           clock enable; low freezes every register
//   start         start pulse, honoured only in IDLE or DONE
//   n_in          operand, captured on an accepted start
//   factor_out    current factor, stable while factor_valid is high
//   factor_valid  a factor is being presented
//   factor_ready  consumer accepts the presented factor
//   factor_last   the presented factor is the final one
//   busy          high from an accepted start until DONE is reached
//   done          high in DONE until the next accepted start
//   is_zero       captured operand was zero (meaningful while done)
//   is_prime      captured operand is prime (meaningful while done)
//   factor_count  number of factors handed over so far

module seq_factorizer #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic [WIDTH-1:0] n_in,
    output logic [WIDTH-1:0] factor_out,
    output logic             factor_valid,
    input  logic             factor_ready,
    output logic             factor_last,
    output logic             busy,
    output logic             done,
    output logic             is_zero,
    output logic             is_prime,
    output logic [CW-1:0]    factor_count
);

    localparam int BW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        DIV,
        EMIT,
        DONE
    } state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   rem, rem_nxt;
    logic [WIDTH-1:0]   d, d_nxt;
    logic [2*WIDTH-1:0] sq, sq_nxt;
    logic [WIDTH-1:0]   div_q, div_q_nxt;
    logic [WIDTH-1:0]   div_r, div_r_nxt;
    logic [BW-1:0]      bit_cnt, bit_cnt_nxt;
    logic [WIDTH-1:0]   n_cap, n_cap_nxt;
    logic [WIDTH-1:0]   factor_out_nxt;
    logic               factor_last_nxt;
    logic [CW-1:0]      factor_count_nxt;
    logic               is_zero_nxt;
    logic               is_prime_nxt;

    logic [WIDTH:0]     trial;
    logic               trial_ge;
    logic [WIDTH-1:0]   div_r_step;
    logic [WIDTH-1:0]   div_q_step;

    // One restoring-division step. The dividend shifts out of div_q MSB
    // first while quotient bits shift in at the bottom. After WIDTH steps
    // div_q holds the quotient and div_r the remainder. The partial
    // remainder stays below 2*d, so one extra bit is enough for the trial.
    always_comb begin
        trial      = {div_r, div_q[WIDTH-1]};
        trial_ge   = (trial >= {1'b0, d});
        div_r_step = trial_ge ? WIDTH'(trial - {1'b0, d}) : trial[WIDTH-1:0];
        div_q_step = {div_q[WIDTH-2:0], trial_ge};
    end

    // Next-state and datapath decisions. Every register keeps its value
    // unless its state says otherwise. sq tracks d*d incrementally, using
    // (d+1)^2 = d^2 + 2d + 1, so no multiplier is needed.
    always_comb begin
        state_nxt        = state;
        rem_nxt          = rem;
        d_nxt            = d;
        sq_nxt           = sq;
        div_q_nxt        = div_q;
        div_r_nxt        = div_r;
        bit_cnt_nxt      = bit_cnt;
        n_cap_nxt        = n_cap;
        factor_out_nxt   = factor_out;
        factor_last_nxt  = factor_last;
        factor_count_nxt = factor_count;
        is_zero_nxt      = is_zero;
        is_prime_nxt     = is_prime;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    rem_nxt          = n_in;
                    n_cap_nxt        = n_in;
                    d_nxt            = WIDTH'(2);
                    sq_nxt           = (2*WIDTH)'(4);
                    factor_count_nxt = '0;
                    is_zero_nxt      = 1'b0;
                    is_prime_nxt     = 1'b0;
                    state_nxt        = CHECK;
                end
            end

            CHECK: begin
                if (rem == '0) begin
                    is_zero_nxt = 1'b1;
                    state_nxt   = DONE;
                end else if (rem == WIDTH'(1)) begin
                    state_nxt = DONE;
                end else if (sq > {{WIDTH{1'b0}}, rem}) begin
                    // No divisor up to sqrt(rem) is left, so rem itself is prime.
                    factor_out_nxt  = rem;
                    factor_last_nxt = 1'b1;
                    state_nxt       = EMIT;
                end else begin
                    div_q_nxt   = rem;
                    div_r_nxt   = '0;
                    bit_cnt_nxt = '0;
                    state_nxt   = DIV;
                end
            end

            DIV: begin
                div_q_nxt   = div_q_step;
                div_r_nxt   = div_r_step;
                bit_cnt_nxt = bit_cnt + BW'(1);
                if (bit_cnt == BW'(WIDTH - 1)) begin
                    if (div_r_step == '0) begin
                        factor_out_nxt  = d;
                        factor_last_nxt = (div_q_step == WIDTH'(1));
                        rem_nxt         = div_q_step;
                        state_nxt       = EMIT;
                    end else begin
                        sq_nxt    = sq + {{(WIDTH-1){1'b0}}, d, 1'b1};
                        d_nxt     = d + WIDTH'(1);
                        state_nxt = CHECK;
                    end
                end
            end

            EMIT: begin
                if (factor_ready) begin
                    factor_count_nxt = factor_count + CW'(1);
                    if (factor_last) begin
                        rem_nxt      = WIDTH'(1);
                        // The operand is prime only if it left as one factor equal to itself.
                        is_prime_nxt = (factor_count == '0) && (factor_out == n_cap) &&
                                       (n_cap > WIDTH'(1));
                        state_nxt    = DONE;
                    end else begin
                        state_nxt = CHECK;
                    end
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    // The state register and all datapath registers. Reset is asynchronous.
    // With ena low, nothing advances, including handshakes and divider steps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            rem          <= '0;
            d            <= '0;
            sq           <= '0;
            div_q        <= '0;
            div_r        <= '0;
            bit_cnt      <= '0;
            n_cap        <= '0;
            factor_out   <= '0;
            factor_last  <= 1'b0;
            factor_count <= '0;
            is_zero      <= 1'b0;
            is_prime     <= 1'b0;
        end else if (ena) begin
            state        <= state_nxt;
            rem          <= rem_nxt;
            d            <= d_nxt;
            sq           <= sq_nxt;
            div_q        <= div_q_nxt;
            div_r        <= div_r_nxt;
            bit_cnt      <= bit_cnt_nxt;
            n_cap        <= n_cap_nxt;
            factor_out   <= factor_out_nxt;
            factor_last  <= factor_last_nxt;
            factor_count <= factor_count_nxt;
            is_zero      <= is_zero_nxt;
            is_prime     <= is_prime_nxt;
        end
    end

    // The status outputs decode the registered state, so they never follow
    // the inputs combinationally.
    always_comb begin
        factor_valid = (state == EMIT);
        busy         = (state == CHECK) || (state == DIV) || (state == EMIT);
        done         = (state == DONE);
    end

endmodule

// File: tb/tb_seq_factorizer.sv
// tb_seq_factorizer
//
// Bench for seq_factorizer. It instantiates one WIDTH=8 unit and one
// WIDTH=12 unit. A table of operands is compared against hand-factored
// expectations. Hand-written sequences cover the following:
//   - a stalled, clock-gated stream with an ignored mid-run start
//   - a reset applied in the middle of a division
//   - a 12-bit operand

module tb_seq_factorizer;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic        start;
    logic        factor_ready;
    logic [7:0]  n8;
    logic [11:0] n12;
    logic        sel;

    logic [7:0]  f8;
    logic        v8, l8, b8, d8, z8, p8;
    logic [3:0]  c8;
    logic [11:0] f12;
    logic        v12, l12, b12, d12, z12, p12;
    logic [3:0]  c12;

    logic        v_valid, v_last, v_busy, v_done, v_zero, v_prime;
    int          v_factor, v_count;

    int          checks;
    int          errors;
    int          got_n;
    int          got_f[16];
    bit          got_l[16];

    localparam int BUDGET = 3000;

    typedef struct packed {
        logic [15:0] n;
        logic [3:0]  nf;
        logic        zero;
        logic        prime;
    } vec_t;

    seq_factorizer #(.WIDTH(8)) dut8 (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .start        (start & ~sel),
        .n_in         (n8),
        .factor_out   (f8),
        .factor_valid (v8),
        .factor_ready (factor_ready),
        .factor_last  (l8),
        .busy         (b8),
        .done         (d8),
        .is_zero      (z8),
        .is_prime     (p8),
        .factor_count (c8)
    );

    seq_factorizer #(.WIDTH(12)) dut12 (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .start        (start & sel),
        .n_in         (n12),
        .factor_out   (f12),
        .factor_valid (v12),
        .factor_ready (factor_ready),
        .factor_last  (l12),
        .busy         (b12),
        .done         (d12),
        .is_zero      (z12),
        .is_prime     (p12),
        .factor_count (c12)
    );

    // Presents whichever unit is under test through one set of views.
    always_comb begin
        v_valid  = sel ? v12 : v8;
        v_last   = sel ? l12 : l8;
        v_busy   = sel ? b12 : b8;
        v_done   = sel ? d12 : d8;
        v_zero   = sel ? z12 : z8;
        v_prime  = sel ? p12 : p8;
        v_factor = sel ? int'(f12) : int'(f8);
        v_count  = sel ? int'(c12) : int'(c8);
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stops the run if something stalls without reaching the summary.
    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Starts one operation and watches it to DONE. Every handshake is
    // recorded in got_f/got_l. In stress mode, factor_ready is random, ena
    // drops in bursts, and a stray start with a different operand is
    // pulsed mid-run. That start must be ignored.
    task automatic applyStimulus(input int n, input bit use12, input bit stress);
        int  cycles;
        int  burst;
        bit  finished;
        bit  hs;
        bit  prev_stall;
        int  prev_factor;
        bit  prev_last;
        sel        = use12;
        got_n      = 0;
        cycles     = 0;
        burst      = 0;
        finished   = 0;
        prev_stall = 0;
        prev_factor = 0;
        prev_last  = 0;
        @(negedge clk);
        n8           = n[7:0];
        n12          = n[11:0];
        start        = 1'b1;
        ena          = 1'b1;
        factor_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput($sformatf("busy_after_start_%0d", n), int'(v_busy), 1);
        while (!finished && cycles < BUDGET) begin
            if (stress) begin
                factor_ready = 1'($urandom_range(0, 1));
                if (burst > 0) begin
                    ena = 1'b0;
                    burst--;
                end else begin
                    ena = 1'b1;
                    if ($urandom_range(0, 9) == 0) burst = $urandom_range(1, 4);
                end
                if (cycles == 25) begin
                    start = 1'b1;
                    n8    = 8'd7;
                    n12   = 12'd7;
                end else begin
                    start = 1'b0;
                    n8    = n[7:0];
                    n12   = n[11:0];
                end
            end
            if (prev_stall) begin
                checkOutput("stall_valid_held", int'(v_valid), 1);
                checkOutput("stall_factor_stable", v_factor, prev_factor);
                checkOutput("stall_last_stable", int'(v_last), int'(prev_last));
            end
            hs = v_valid && factor_ready && ena;
            if (hs && got_n < 16) begin
                got_f[got_n] = v_factor;
                got_l[got_n] = v_last;
                got_n++;
            end
            prev_stall  = v_valid && !hs;
            prev_factor = v_factor;
            prev_last   = v_last;
            if (v_done) begin
                finished = 1;
            end else begin
                @(negedge clk);
                cycles++;
            end
        end
        start        = 1'b0;
        ena          = 1'b1;
        factor_ready = 1'b1;
        n8           = n[7:0];
        n12          = n[11:0];
        if (!finished) checkOutput($sformatf("timeout_%0d", n), 0, 1);
    endtask

    vec_t vecs[10];
    int   flat[20];

    initial begin
        int idx;
        checks       = 0;
        errors       = 0;
        sel          = 1'b0;
        ena          = 1'b1;
        start        = 1'b0;
        factor_ready = 1'b1;
        n8           = '0;
        n12          = '0;
        rst_n        = 1'b0;

        vecs[0] = '{n: 16'd12,  nf: 4'd3, zero: 1'b0, prime: 1'b0};
        vecs[1] = '{n: 16'd251, nf: 4'd1, zero: 1'b0, prime: 1'b1};
        vecs[2] = '{n: 16'd0,   nf: 4'd0, zero: 1'b1, prime: 1'b0};
        vecs[3] = '{n: 16'd1,   nf: 4'd0, zero: 1'b0, prime: 1'b0};
        vecs[4] = '{n: 16'd2,   nf: 4'd1, zero: 1'b0, prime: 1'b1};
        vecs[5] = '{n: 16'd4,   nf: 4'd2, zero: 1'b0, prime: 1'b0};
        vecs[6] = '{n: 16'd128, nf: 4'd7, zero: 1'b0, prime: 1'b0};
        vecs[7] = '{n: 16'd255, nf: 4'd3, zero: 1'b0, prime: 1'b0};
        vecs[8] = '{n: 16'd9,   nf: 4'd2, zero: 1'b0, prime: 1'b0};
        vecs[9] = '{n: 16'd97,  nf: 4'd1, zero: 1'b0, prime: 1'b1};
        flat = '{2, 2, 3,  251,  2,  2, 2,  2, 2, 2, 2, 2, 2, 2,
                 3, 5, 17,  3, 3,  97};

        // Both units must hold every output at zero while in reset.
        #12;
        checkOutput("reset_outputs_w8",  int'({f8, v8, l8, b8, d8, z8, p8, c8}), 0);
        checkOutput("reset_outputs_w12", int'({f12, v12, l12, b12, d12, z12, p12, c12}), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven operands on the 8-bit unit, consumer always ready.
        idx = 0;
        for (int k = 0; k < 10; k++) begin
            applyStimulus(int'(vecs[k].n), 1'b0, 1'b0);
            checkOutput($sformatf("n%0d_count_seen", vecs[k].n), got_n, int'(vecs[k].nf));
            for (int i = 0; i < int'(vecs[k].nf); i++) begin
                if (i < got_n) begin
                    checkOutput($sformatf("n%0d_factor%0d", vecs[k].n, i), got_f[i], flat[idx + i]);
                    checkOutput($sformatf("n%0d_last%0d", vecs[k].n, i), int'(got_l[i]),
                                (i == int'(vecs[k].nf) - 1) ? 1 : 0);
                end
            end
            idx += int'(vecs[k].nf);
            checkOutput($sformatf("n%0d_done", vecs[k].n), int'(v_done), 1);
            checkOutput($sformatf("n%0d_busy", vecs[k].n), int'(v_busy), 0);
            checkOutput($sformatf("n%0d_valid", vecs[k].n), int'(v_valid), 0);
            checkOutput($sformatf("n%0d_is_zero", vecs[k].n), int'(v_zero), int'(vecs[k].zero));
            checkOutput($sformatf("n%0d_is_prime", vecs[k].n), int'(v_prime), int'(vecs[k].prime));
            checkOutput($sformatf("n%0d_factor_count", vecs[k].n), v_count, int'(vecs[k].nf));
        end

        // 200 under random back-pressure and ena bursts, with a stray start.
        applyStimulus(200, 1'b0, 1'b1);
        checkOutput("n200_stress_count_seen", got_n, 5);
        for (int i = 0; i < 5; i++) begin
            if (i < got_n) begin
                checkOutput($sformatf("n200_stress_factor%0d", i), got_f[i], (i < 3) ? 2 : 5);
                checkOutput($sformatf("n200_stress_last%0d", i), int'(got_l[i]), (i == 4) ? 1 : 0);
            end
        end
        checkOutput("n200_stress_factor_count", v_count, 5);
        checkOutput("n200_stress_is_prime", int'(v_prime), 0);

        // Reset in the middle of a division on 221.
        sel = 1'b0;
        @(negedge clk);
        n8    = 8'd221;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("n221_busy_before_reset", int'(b8), 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("n221_reset_outputs", int'({f8, v8, l8, b8, d8, z8, p8, c8}), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("n221_in_reset_valid", int'(v8), 0);
        end
        rst_n = 1'b1;
        applyStimulus(221, 1'b0, 1'b0);
        checkOutput("n221_count_seen", got_n, 2);
        if (got_n >= 2) begin
            checkOutput("n221_factor0", got_f[0], 13);
            checkOutput("n221_factor1", got_f[1], 17);
            checkOutput("n221_last0", int'(got_l[0]), 0);
            checkOutput("n221_last1", int'(got_l[1]), 1);
        end
        checkOutput("n221_factor_count", v_count, 2);
        checkOutput("n221_is_prime", int'(v_prime), 0);

        // 4095 on the 12-bit unit.
        applyStimulus(4095, 1'b1, 1'b0);
        checkOutput("n4095_count_seen", got_n, 5);
        for (int i = 0; i < 5; i++) begin
            int exp12;
            case (i)
                0, 1:    exp12 = 3;
                2:       exp12 = 5;
                3:       exp12 = 7;
                default: exp12 = 13;
            endcase
            if (i < got_n) begin
                checkOutput($sformatf("n4095_factor%0d", i), got_f[i], exp12);
                checkOutput($sformatf("n4095_last%0d", i), int'(got_l[i]), (i == 4) ? 1 : 0);
            end
        end
        checkOutput("n4095_factor_count", v_count, 5);
        checkOutput("n4095_done", int'(v_done), 1);
        checkOutput("n4095_is_prime", int'(v_prime), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
